// File: rtl/axis_mem_if.sv
// axis_mem_if: load-request, load-payload and store AXI-stream bundle.
// Modports: master = kernel side, slave = memory responder side.
interface axis_mem_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            s_axis_req_tdata;
    logic                             s_axis_req_tvalid;
    logic                             s_axis_req_tready;
    logic                             s_axis_req_tlast;

    logic [DATA_WIDTH-1:0]            m_axis_pl_tdata;
    logic                             m_axis_pl_tvalid;
    logic                             m_axis_pl_tready;
    logic                             m_axis_pl_tlast;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_st_tdata;
    logic                             s_axis_st_tvalid;
    logic                             s_axis_st_tready;
    logic                             s_axis_st_tlast;

    modport master (
        output s_axis_req_tdata, s_axis_req_tvalid, s_axis_req_tlast,
        input  s_axis_req_tready,
        input  m_axis_pl_tdata, m_axis_pl_tvalid, m_axis_pl_tlast,
        output m_axis_pl_tready,
        output s_axis_st_tdata, s_axis_st_tvalid, s_axis_st_tlast,
        input  s_axis_st_tready
    );

    modport slave (
        input  s_axis_req_tdata, s_axis_req_tvalid, s_axis_req_tlast,
        output s_axis_req_tready,
        output m_axis_pl_tdata, m_axis_pl_tvalid, m_axis_pl_tlast,
        input  m_axis_pl_tready,
        input  s_axis_st_tdata, s_axis_st_tvalid, s_axis_st_tlast,
        output s_axis_st_tready
    );
endinterface

// File: rtl/axis_mem_responder.sv
// axis_mem_responder: word-array memory answering in-order AXI-stream loads
// and applying {addr,data} store beats.
// Ports: clk, reset (sync, active-high); bus (axis_mem_if.slave: req/pl/st
// streams); st_done (pulse after a tlast store); init_we/addr/data (preload,
// highest write priority); err (sticky range error).
// Optional: define AXIS_MEM_BOUNDS_CHECK_EN to range-check every access
// against DEPTH; otherwise err is 0 and the array uses low address bits.
module axis_mem_responder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_mem_if.slave             bus,
    output logic                  st_done,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    output logic                  err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   FD_W     = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_last_q, rd_last_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  st_done_q, st_done_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [CW:0]           outstanding;
    logic                  req_ready, req_fire;
    logic                  st_ready, st_fire;
    logic                  fifo_empty;
    logic                  pl_valid, pl_fire;
    logic                  push, pop_fifo;
    logic                  ld_oob, st_oob, init_oob;
    logic                  st_we, init_wr;
    logic [DATA_WIDTH-1:0] ld_word;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign req_addr = bus.s_axis_req_tdata;
    assign st_addr  = bus.s_axis_st_tdata[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    assign st_data  = bus.s_axis_st_tdata[DATA_WIDTH-1:0];

    // Every accepted request owns a FIFO slot, either buffered or still
    // being read, so readiness never depends on the downstream tready.
    assign outstanding = {1'b0, count_q} + (CW + 1)'(inflight_q);
    assign req_ready   = !reset && (outstanding < FD_W);
    assign req_fire    = bus.s_axis_req_tvalid && req_ready;
    assign st_ready    = !reset;
    assign st_fire     = bus.s_axis_st_tvalid && st_ready;

    // An empty FIFO lets the freshly read word out directly; if it is not
    // taken it drops into the FIFO, so the presented beat stays stable.
    assign fifo_empty = (count_q == '0);
    assign pl_valid   = !reset && (!fifo_empty || inflight_q);
    assign pl_fire    = pl_valid && bus.m_axis_pl_tready;
    assign push       = inflight_q && !(fifo_empty && pl_fire);
    assign pop_fifo   = pl_fire && !fifo_empty;

    always_comb begin
        ld_oob   = 1'b0;
        st_oob   = 1'b0;
        init_oob = 1'b0;
`ifdef AXIS_MEM_BOUNDS_CHECK_EN
        ld_oob   = 32'(req_addr) >= DEPTH;
        st_oob   = 32'(st_addr) >= DEPTH;
        init_oob = 32'(init_addr) >= DEPTH;
`endif
    end

    assign st_we   = st_fire && !st_oob;
    assign init_wr = init_we && !init_oob;
    assign ld_word = ld_oob ? '0 : mem_q[req_addr[IW-1:0]];

    always_comb begin
        rd_data_d  = req_fire ? ld_word : rd_data_q;
        rd_last_d  = req_fire ? bus.s_axis_req_tlast : rd_last_q;
        inflight_d = req_fire;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop_fifo ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop_fifo);
        st_done_d  = st_fire && bus.s_axis_st_tlast;
`ifdef AXIS_MEM_BOUNDS_CHECK_EN
        err_d = err_q | (req_fire && ld_oob) | (st_fire && st_oob)
              | (init_we && init_oob);
`else
        err_d = 1'b0;
`endif
    end

    // Array and data paths carry no reset; contents survive reset.
    // The init write is last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (st_we) mem_q[st_addr[IW-1:0]] <= st_data;
        if (init_wr) mem_q[init_addr[IW-1:0]] <= init_data;
        rd_data_q <= rd_data_d;
        rd_last_q <= rd_last_d;
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_data_q;
            fifo_last_q[wr_ptr_q] <= rd_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            st_done_q  <= st_done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        bus.m_axis_pl_tdata = '0;
        bus.m_axis_pl_tlast = 1'b0;
        if (pl_valid) begin
            bus.m_axis_pl_tdata = fifo_empty ? rd_data_q : fifo_data_q[rd_ptr_q];
            bus.m_axis_pl_tlast = fifo_empty ? rd_last_q : fifo_last_q[rd_ptr_q];
        end
    end

    assign bus.m_axis_pl_tvalid  = pl_valid;
    assign bus.s_axis_req_tready = req_ready;
    assign bus.s_axis_st_tready  = st_ready;
    assign st_done = st_done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_axis_mem_responder.sv
// tb_axis_mem_responder: directed + random stimulus for axis_mem_responder,
// checked every cycle against a queue-based memory/stream model.
module tb_axis_mem_responder;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int FD = 3;
`ifdef AXIS_MEM_BOUNDS_CHECK_EN
    localparam int DEPTH = 9;
`else
    localparam int DEPTH = 16;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          st_done;
    logic          err;
    logic          init_we = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [DW-1:0] init_data = '0;

    axis_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axis_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .st_done(st_done),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mem_m [16];
    bit            done_m;
    bit            err_m;
    bit            acc;
    int            cyc;
    int            errors;
    int            checks;

    function automatic bit in_range(logic [AW-1:0] a);
`ifdef AXIS_MEM_BOUNDS_CHECK_EN
        return int'(a) < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(bit v, logic [AW-1:0] a, bit l);
        bus.s_axis_req_tvalid = v;
        bus.s_axis_req_tdata  = a;
        bus.s_axis_req_tlast  = l;
    endtask

    task automatic set_st(bit v, logic [AW-1:0] a, logic [DW-1:0] d, bit l);
        bus.s_axis_st_tvalid = v;
        bus.s_axis_st_tdata  = {a, d};
        bus.s_axis_st_tlast  = l;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model
    // with whatever the handshakes of this cycle commit at the edge.
    task automatic tick();
        bit            exp_ready;
        bit            exp_v;
        exp_t          e;
        logic [AW-1:0] sa;
        @(negedge clk);
        exp_ready = q.size() < FD;
        exp_v = (q.size() > 0) && (q[0].cyc < cyc);
        if (reset) begin
            chk("rst_pl_tvalid", bus.m_axis_pl_tvalid, 0);
            chk("rst_req_tready", bus.s_axis_req_tready, 0);
            chk("rst_st_tready", bus.s_axis_st_tready, 0);
        end else begin
            chk("req_tready", bus.s_axis_req_tready, exp_ready);
            chk("st_tready", bus.s_axis_st_tready, 1);
            chk("st_done", st_done, done_m);
            chk("err", err, err_m);
            chk("pl_tvalid", bus.m_axis_pl_tvalid, exp_v);
            if (exp_v) begin
                chk("pl_tdata", bus.m_axis_pl_tdata, q[0].data);
                chk("pl_tlast", bus.m_axis_pl_tlast, q[0].last);
            end
        end
        acc = 1'b0;
        if (reset) begin
            q.delete();
            done_m = 1'b0;
            err_m  = 1'b0;
        end else begin
            if (exp_v && bus.m_axis_pl_tready) void'(q.pop_front());
            done_m = bus.s_axis_st_tvalid && bus.s_axis_st_tlast;
            if (bus.s_axis_req_tvalid && exp_ready) begin
                acc    = 1'b1;
                e.last = bus.s_axis_req_tlast;
                e.cyc  = cyc;
                if (in_range(bus.s_axis_req_tdata)) begin
                    e.data = mem_m[bus.s_axis_req_tdata];
                end else begin
                    e.data = '0;
                    err_m  = 1'b1;
                end
                q.push_back(e);
            end
            if (bus.s_axis_st_tvalid) begin
                sa = bus.s_axis_st_tdata[AW+DW-1 -: AW];
                if (in_range(sa)) mem_m[sa] = bus.s_axis_st_tdata[DW-1:0];
                else err_m = 1'b1;
            end
        end
        if (init_we) begin
            if (in_range(init_addr)) mem_m[init_addr] = init_data;
            else if (!reset) err_m = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int            n;
        logic [AW-1:0] stall_addr [5];
        logic [AW-1:0] ra;

        errors = 0;
        checks = 0;
        cyc    = 0;
        set_req(0, '0, 0);
        set_st(0, '0, '0, 0);
        bus.m_axis_pl_tready = 1'b1;

        idle(3);
        reset = 1'b0;
        chk("reset_tdata", bus.m_axis_pl_tdata, 0);
        chk("reset_tlast", bus.m_axis_pl_tlast, 0);
        chk("reset_st_done", st_done, 0);
        chk("reset_err", err, 0);

        for (int i = 0; i < DEPTH; i++) begin
            init_we   = 1'b1;
            init_addr = AW'(i);
            init_data = DW'(100 + i);
            tick();
        end
        init_we = 1'b0;

        // Back-to-back loads 3,7,0 with tlast on the last one.
        set_req(1, 3, 0);
        tick();
        set_req(1, 7, 0);
        tick();
        set_req(1, 0, 1);
        tick();
        set_req(0, '0, 0);
        idle(3);

        // Backpressure: five requests against a stalled consumer.
        stall_addr = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd8};
        bus.m_axis_pl_tready = 1'b0;
        n = 0;
        for (int c = 0; c < 8 && n < 5; c++) begin
            set_req(1, stall_addr[n], n == 4);
            tick();
            if (acc) n++;
        end
        chk("stall_accepts", n, 3);
        chk("stall_ready", bus.s_axis_req_tready, 0);
        bus.m_axis_pl_tready = 1'b1;
        for (int c = 0; c < 10 && n < 5; c++) begin
            set_req(1, stall_addr[n], n == 4);
            tick();
            if (acc) n++;
        end
        set_req(0, '0, 0);
        chk("stall_total", n, 5);
        idle(4);
        chk("stall_drain", q.size(), 0);

        // Same-cycle store and load of address 2 read the old word.
        init_we   = 1'b1;
        init_addr = 2;
        init_data = 32'hAAAA;
        tick();
        init_we = 1'b0;
        set_req(1, 2, 0);
        set_st(1, 2, 32'h5555, 0);
        tick();
        set_st(0, '0, '0, 0);
        set_req(1, 2, 1);
        tick();
        set_req(0, '0, 0);
        idle(3);

        // Store burst 0..3, tlast on the fourth beat, then read back.
        for (int i = 0; i < 4; i++) begin
            set_st(1, AW'(i), DW'(32'h1000 + i), i == 3);
            tick();
        end
        set_st(0, '0, '0, 0);
        chk("st_done_pulse", st_done, 1);
        tick();
        chk("st_done_clear", st_done, 0);
        for (int i = 0; i < 4; i++) begin
            set_req(1, AW'(i), i == 3);
            tick();
        end
        set_req(0, '0, 0);
        idle(3);

        // Reset with two payloads buffered and one read in flight.
        bus.m_axis_pl_tready = 1'b0;
        n = 0;
        for (int c = 0; c < 6 && n < 3; c++) begin
            set_req(1, AW'(5 + n), 0);
            tick();
            if (acc) n++;
        end
        set_req(0, '0, 0);
        chk("pre_reset_accepts", n, 3);
        reset = 1'b1;
        tick();
        chk("in_reset_tvalid", bus.m_axis_pl_tvalid, 0);
        reset = 1'b0;
        bus.m_axis_pl_tready = 1'b1;
        chk("post_reset_tvalid", bus.m_axis_pl_tvalid, 0);
        idle(5);

        // Random traffic on all three streams plus preload writes.
        for (int c = 0; c < 500; c++) begin
`ifdef AXIS_MEM_BOUNDS_CHECK_EN
            ra = AW'($urandom_range(15));
`else
            ra = AW'($urandom_range(DEPTH - 1));
`endif
            set_req($urandom_range(3) != 0, ra, $urandom_range(1));
            set_st($urandom_range(2) == 0, AW'($urandom_range(DEPTH - 1)),
                   $urandom, $urandom_range(3) == 0);
            bus.m_axis_pl_tready = $urandom_range(3) != 0;
            init_we   = $urandom_range(15) == 0;
            init_addr = AW'($urandom_range(DEPTH - 1));
            init_data = $urandom;
            tick();
        end
        set_req(0, '0, 0);
        set_st(0, '0, '0, 0);
        init_we = 1'b0;
        bus.m_axis_pl_tready = 1'b1;
        idle(5);
        chk("random_drain", q.size(), 0);

`ifdef AXIS_MEM_BOUNDS_CHECK_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("oob_err_clear", err, 0);
        set_req(1, 12, 1);
        tick();
        set_req(0, '0, 0);
        chk("oob_load_err", err, 1);
        chk("oob_load_data", bus.m_axis_pl_tdata, 0);
        chk("oob_load_last", bus.m_axis_pl_tlast, 1);
        set_st(1, 10, 32'hDEAD, 0);
        tick();
        set_st(0, '0, '0, 0);
        idle(3);
        chk("oob_err_sticky", err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("oob_err_reset", err, 0);
        idle(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_mem_responder.md
Name: axis_mem_responder

Overview:
- Memory-side stage that terminates the AXI-stream load-request, load-payload and store streams produced by the per-memory handshake/AXI adapters in a kernel top.
- Holds a local synchronous-read word array. Answers each load request in order on the payload stream. Applies store beats of packed {address, data}.
- Used as the memory model in kernel testbenches and as a small on-chip scratch memory in integration builds.

Parameters:
- ADDR_WIDTH, 4, width of load and store address fields.
- DATA_WIDTH, 32, word width.
- DEPTH, 16, number of words; must be >= 1 and <= 2**ADDR_WIDTH.
- FIFO_DEPTH, 3, payload output buffer entries; must be >= 3 for full throughput.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_req_tdata  in  ADDR_WIDTH  load address.
- s_axis_req_tvalid  in  1  load request valid.
- s_axis_req_tready  out  1  load request accept.
- s_axis_req_tlast  in  1  last request of a burst.
- m_axis_pl_tdata  out  DATA_WIDTH  load data.
- m_axis_pl_tvalid  out  1  load data valid.
- m_axis_pl_tready  in  1  load data accept.
- m_axis_pl_tlast  out  1  copy of the tlast of the matching request.
- s_axis_st_tdata  in  ADDR_WIDTH+DATA_WIDTH  store beat; address in MSBs, data in LSBs.
- s_axis_st_tvalid  in  1  store valid.
- s_axis_st_tready  out  1  store accept.
- s_axis_st_tlast  in  1  last store of a burst.
- st_done  out  1  one-cycle pulse after a tlast store beat is written.
- init_we  in  1  testbench preload write enable.
- init_addr  in  ADDR_WIDTH  preload address.
- init_data  in  DATA_WIDTH  preload data.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values:
  - s_axis_req_tready=0, s_axis_st_tready=0, m_axis_pl_tvalid=0, m_axis_pl_tlast=0, m_axis_pl_tdata=0, st_done=0, err=0.
  - FIFO empty; in-flight flag cleared.
  - Array contents are not cleared.
- Load path: a request is accepted when s_axis_req_tvalid && s_axis_req_tready.
  - Cycle t: accept; array read registered; in-flight flag set.
  - Cycle t+1: word plus tlast pushed into the FIFO.
  - If the FIFO was empty, m_axis_pl_tvalid=1 in cycle t+1 (first-word latency 1 cycle).
- s_axis_req_tready = (fifo_count + inflight) < FIFO_DEPTH.
  - Computed from registered state only; there is no combinational path from m_axis_pl_tready.
  - Sustains 1 request/cycle while m_axis_pl_tready=1.
- Payload: m_axis_pl_tvalid/tdata/tlast are held stable while tvalid && !tready. Order is strict FIFO and matches request order.
- Store path: s_axis_st_tready=1 whenever not in reset. Each accepted beat writes data to address in the same edge.
- Store vs load collision (same cycle, same address): read-first. The load returns the old word and the store lands.
- init_we has the highest write priority. If init_we and a store hit the same cycle, both write; on an address collision the init write wins.
- st_done pulses 1 cycle after the edge that accepts a beat with s_axis_st_tlast=1.
- Back-to-back tlast stores produce back-to-back st_done pulses.
- FIFO full: tready=0 holds the request off. There is no drop and no overwrite.
- FIFO count wraps are impossible by construction. Push and pop in the same cycle keep the count unchanged.
- Reset mid-operation: in-flight reads and buffered payloads are discarded; no payload beat is emitted after reset is released until a new request is accepted.

Optional Feature:
- Macro AXIS_MEM_BOUNDS_CHECK_EN.
- Defined:
  - A load with address >= DEPTH returns 0 (with its tlast) and sets err.
  - A store or init write with address >= DEPTH is dropped and sets err.
  - err stays set until reset.
- Undefined:
  - No range check; the array is indexed with the low bits of the address.
  - Out-of-range access is a configuration error.
  - err is tied 0.

Test Plan:
- Preload words 0..15 with 100+i. Issue requests 3,7,0 back-to-back with tlast on 0, pl_tready=1 -> payload 103,107,100 in cycles t+1..t+3; tlast only on 100; req_tready stays 1.
- Hold pl_tready=0 and issue 5 requests -> exactly 3 accepted, req_tready=0, tvalid held with a stable first word. Release tready -> remaining 2 accepted; all 5 returned in order.
- Preload addr 2 = 0xAAAA. Store {2,0x5555} and load 2 in the same cycle -> payload 0xAAAA. A following load of 2 returns 0x5555.
- Store 4 beats to addresses 0..3 with tlast on the 4th -> one st_done pulse 1 cycle after the last beat; loads then read back the stored data.
- Assert reset with 2 payloads buffered and 1 in flight -> tvalid=0 in the cycle after reset; no stale beat appears after release.
- With AXIS_MEM_BOUNDS_CHECK_EN and DEPTH=9: load 12 -> payload 0, err=1. Store to 10 is dropped; err stays 1 until reset.
